jpeg_rle_decoder: RTL and testbench
===================================

# jpeg_rle_decoder

Inverse of the encoder's run-length stage: consumes (run, size, amplitude) tokens in the format produced by the RLE (`rle`) stage and re-expands them into a zig-zag-ordered stream of 64 quantized coefficients per 8x8 block. It sits in the loopback/verification path after the RLE stage, so encoder output can be checked coefficient-for-coefficient against the pre-RLE stream. Both sides use valid/ready handshakes; one token may expand into up to 16 or 63 output coefficients.

## Interface
- `DW`, 12: amplitude/coefficient width (signed).
- `BLK`, 64: coefficients per block; index width is `$clog2(BLK)`.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `tok_valid` in 1: token present.
- `tok_ready` out 1: decoder accepts the token this cycle.
- `dcterm` in 1: token is the block's DC term.
- `rlen` in 4: zero-run length preceding the amplitude.
- `size` in 4: amplitude category; 0 marks the EOB/ZRL codes.
- `amp` in DW: signed amplitude, already sign-extended.
- `coef_valid` out 1: coefficient present.
- `coef_ready` in 1: downstream accepts the coefficient.
- `coef` out DW: coefficient value.
- `coef_idx` out 6: zig-zag index 0..63.
- `coef_last` out 1: high with index 63.
- `err` out 1: one-cycle pulse on a protocol violation.

## Operation
- Transfers complete on `valid && ready`. Once `coef_valid` is high, `coef`, `coef_idx` and `coef_last` stay stable until accepted.
- The FSM has five states:
  - S_DC: wait for the DC token. `tok_ready=1` when the output slot is free or draining. A token with `dcterm=1` emits `amp` at idx 0, then goes to S_TOK. A token with `dcterm=0` is dropped, pulses `err`, and the FSM stays in S_DC.
  - S_TOK: accept an AC token.
    - EOB (`rlen=0`, `size=0`): go to S_FILL.
    - ZRL (`rlen=15`, `size=0`): load 16 zeros, go to S_ZERO with the amplitude flagged absent.
    - Otherwise: load `rlen` zeros plus the amplitude. With `rlen=0` the amplitude goes straight out and the FSM stays in S_TOK.
  - S_ZERO: emit zeros, decrementing the run counter. At 0, go to S_AMP if an amplitude is pending, else to S_TOK.
  - S_AMP: emit the latched `amp`, then go to S_TOK.
  - S_FILL: emit zeros through idx 63.
- `tok_ready=0` in S_ZERO, S_AMP and S_FILL.
- The index counter increments on each accepted coefficient. After idx 63 it returns to 0 and the FSM returns to S_DC, whatever state it was in.
- Error conditions:
  - A token with `size=0` that is neither EOB nor ZRL: `err` pulses, the token is treated as EOB.
  - A run or amplitude that would pass idx 63: `err` pulses, output is truncated at 63 with `coef_last`, and the remainder of the token is discarded.
  - A `dcterm=1` token accepted in S_TOK: `err` pulses, the partial block is abandoned without `coef_last`, and this token starts a new block at idx 0.

## Timing
- Reset values: `tok_ready=0`, `coef_valid=0`, `coef=0`, `coef_idx=0`, `coef_last=0`, `err=0`, state S_DC. `tok_ready` rises the cycle after `rst` deasserts.
- Latency: a token accepted in cycle N gives its first coefficient (zero or amplitude) with `coef_valid` in N+1. With `coef_ready` held high, a token with `rlen=r` produces zeros in N+1..N+r and the amplitude in N+1+r.
- Throughput is 1 coefficient/cycle. Back-to-back `rlen=0` tokens stream without bubbles, because `tok_ready` includes `coef_ready` when the output slot is occupied.
- `err` is registered and asserts in N+1 for a violation on the token accepted in N.
- A reset asserted mid-block takes effect on the next edge: the partial block is lost and no `coef_last` is emitted.

## Structure
- `jpeg_rle_pkg` holds:
  - the state enum;
  - `RLE_EOB` and `RLE_ZRL` token constants;
  - `BLK_LAST` = 63;
  - a token struct {dcterm, rlen, size, amp}.
- One sub-module, `jpeg_rle_dec_oreg`: a single-entry output register with valid/ready. It provides the stall/hold behaviour and the `can_load` term used to form `tok_ready`.

## Test plan
- DC amp=-37, AC tokens (rlen=0, amp 5), (rlen=2, amp -1), then EOB -> idx 0..3 = -37, 5, 0, 0; idx 4 = -1; idx 5..63 = 0; `coef_last` at 63; 64 coefficients total.
- DC=10, three ZRL, (rlen=14, amp 7) -> 48 zeros then 14 zeros; idx 63 = 7 with `coef_last`; no `err`; next block starts at idx 0.
- Same stream as the first scenario with `coef_ready` toggling randomly -> identical sequence; outputs held stable while stalled; no `tok_ready` pulse lost or duplicated.
- DC, then (rlen=15, size=3, amp=2) when idx=50 -> zeros at idx 51..63, `coef_last` at 63, `err` pulse, amplitude dropped; next block OK.
- Mid-block `dcterm=1` token (amp=9) at idx 20 -> `err` pulse, next coefficient is idx 0 = 9, no `coef_last` for the aborted block.
- `rst` low for one cycle during S_FILL at idx 30 -> `coef_valid=0`, idx 0 and state S_DC on the next cycle; a fresh block then decodes correctly.

Source files
------------

// File: rtl/jpeg_rle_pkg.sv
// Shared types and constants for the JPEG run-length decoder.
// Tokens are {dcterm, rlen, size, amp}; EOB/ZRL are identified by their {rlen, size} pair.
package jpeg_rle_pkg;

  localparam int AMP_W    = 12;
  localparam int IDX_W    = 6;
  localparam int BLK_LAST = 63;

  localparam logic [7:0] RLE_EOB = 8'h00;
  localparam logic [7:0] RLE_ZRL = 8'hF0;

  typedef enum logic [2:0] {
    S_DC,
    S_TOK,
    S_ZERO,
    S_AMP,
    S_FILL
  } state_e;

  typedef struct packed {
    logic                    dcterm;
    logic [3:0]              rlen;
    logic [3:0]              size;
    logic signed [AMP_W-1:0] amp;
  } tok_t;

  // True when writing 'extra' more coefficients after position idx would run past the block end.
  function automatic logic past_end(input logic [IDX_W-1:0] idx, input logic [4:0] extra);
    return ({1'b0, idx} + {2'b00, extra}) > 7'(BLK_LAST);
  endfunction

endpackage

// File: rtl/jpeg_rle_decoder_if.sv
// Token input and coefficient output handshakes of the run-length decoder.
// The master side produces tokens and consumes coefficients; the decoder is the slave.
interface jpeg_rle_decoder_if #(
  parameter int DW = jpeg_rle_pkg::AMP_W
) ();

  logic                 tok_valid;
  logic                 tok_ready;
  logic                 dcterm;
  logic [3:0]           rlen;
  logic [3:0]           size;
  logic signed [DW-1:0] amp;

  logic                 coef_valid;
  logic                 coef_ready;
  logic signed [DW-1:0] coef;
  logic [jpeg_rle_pkg::IDX_W-1:0] coef_idx;
  logic                 coef_last;
  logic                 err;

  modport master (
    output tok_valid, dcterm, rlen, size, amp, coef_ready,
    input  tok_ready, coef_valid, coef, coef_idx, coef_last, err
  );

  modport slave (
    input  tok_valid, dcterm, rlen, size, amp, coef_ready,
    output tok_ready, coef_valid, coef, coef_idx, coef_last, err
  );

endinterface

// File: rtl/jpeg_rle_dec_oreg.sv
// Single-entry output register with valid/ready: holds its payload while stalled and
// reports can_load when a new coefficient may be written this cycle.
module jpeg_rle_dec_oreg
  import jpeg_rle_pkg::*;
#(
  parameter int DW = AMP_W,
  parameter int IW = IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic signed [DW-1:0] in_coef,
  input  logic [IW-1:0]        in_idx,
  input  logic                 in_last,
  output logic                 can_load,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_coef,
  output logic [IW-1:0]        out_idx,
  output logic                 out_last
);

  logic                 valid_q, valid_d;
  logic signed [DW-1:0] coef_q, coef_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    coef_d  = coef_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      coef_d  = in_coef;
      idx_d   = in_idx;
      last_d  = in_last;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      coef_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      coef_q  <= coef_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Draining slot counts as free so back-to-back coefficients need no bubble.
  assign can_load  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_coef  = coef_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;

endmodule

// File: rtl/jpeg_rle_decoder.sv
// Expands (run, size, amplitude) tokens back into 64 zig-zag-ordered coefficients per block.
// The first coefficient of an accepted token is written to the output register in the same cycle.
module jpeg_rle_decoder
  import jpeg_rle_pkg::*;
#(
  parameter int DW  = AMP_W,
  parameter int BLK = 64
) (
  input  logic              clk,
  input  logic              rst,
  jpeg_rle_decoder_if.slave bus
);

  localparam int IW = $clog2(BLK);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [4:0]           run_q, run_d;
  logic signed [DW-1:0] amp_q, amp_d;
  logic                 pend_q, pend_d;
  logic                 err_q, err_d;
  logic                 live_q;

  tok_t                 tok;
  logic                 tok_rdy;
  logic                 tok_fire;
  logic                 can_load;
  logic                 ld;
  logic signed [DW-1:0] ld_coef;
  logic [IW-1:0]        ld_idx;
  logic                 ld_last;

  assign tok      = {bus.dcterm, bus.rlen, bus.size, bus.amp};
  assign tok_rdy  = live_q && (state_q == S_DC || state_q == S_TOK) && can_load;
  assign tok_fire = bus.tok_valid && tok_rdy;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    run_d   = run_q;
    amp_d   = amp_q;
    pend_d  = pend_q;
    err_d   = 1'b0;
    ld      = 1'b0;
    ld_coef = '0;
    ld_idx  = idx_q;
    ld_last = 1'b0;

    case (state_q)
      S_DC: begin
        if (tok_fire) begin
          if (tok.dcterm) begin
            ld      = 1'b1;
            ld_coef = tok.amp;
            state_d = S_TOK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_TOK: begin
        if (tok_fire) begin
          if (tok.dcterm) begin
            // Abandon the partial block; this DC restarts at index 0.
            err_d   = 1'b1;
            ld      = 1'b1;
            ld_coef = tok.amp;
            ld_idx  = '0;
            run_d   = '0;
            pend_d  = 1'b0;
          end else if (tok.size == 4'd0) begin
            ld = 1'b1;
            if ({tok.rlen, tok.size} == RLE_ZRL) begin
              err_d   = past_end(idx_q, 5'd15);
              run_d   = 5'd15;
              pend_d  = 1'b0;
              state_d = S_ZERO;
            end else begin
              err_d   = ({tok.rlen, tok.size} != RLE_EOB);
              state_d = S_FILL;
            end
          end else if (tok.rlen == 4'd0) begin
            ld      = 1'b1;
            ld_coef = tok.amp;
          end else begin
            ld      = 1'b1;
            err_d   = past_end(idx_q, {1'b0, tok.rlen});
            amp_d   = tok.amp;
            pend_d  = 1'b1;
            run_d   = {1'b0, tok.rlen} - 5'd1;
            state_d = (tok.rlen == 4'd1) ? S_AMP : S_ZERO;
          end
        end
      end
      S_ZERO: begin
        if (can_load) begin
          ld    = 1'b1;
          run_d = run_q - 5'd1;
          if (run_q == 5'd1) begin
            state_d = pend_q ? S_AMP : S_TOK;
          end
        end
      end
      S_AMP: begin
        if (can_load) begin
          ld      = 1'b1;
          ld_coef = amp_q;
          pend_d  = 1'b0;
          state_d = S_TOK;
        end
      end
      S_FILL: begin
        if (can_load) begin
          ld = 1'b1;
        end
      end
      default: state_d = S_DC;
    endcase

    // Index 63 always closes the block, truncating whatever the current token still owed.
    ld_last = (ld_idx == IW'(BLK_LAST));
    if (ld) begin
      if (ld_last) begin
        state_d = S_DC;
        idx_d   = '0;
        run_d   = '0;
        pend_d  = 1'b0;
      end else begin
        idx_d = ld_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_DC;
      idx_q   <= '0;
      run_q   <= '0;
      amp_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      amp_q   <= amp_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  jpeg_rle_dec_oreg #(
    .DW (DW),
    .IW (IW)
  ) u_oreg (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .in_coef   (ld_coef),
    .in_idx    (ld_idx),
    .in_last   (ld_last),
    .can_load  (can_load),
    .out_valid (bus.coef_valid),
    .out_ready (bus.coef_ready),
    .out_coef  (bus.coef),
    .out_idx   (bus.coef_idx),
    .out_last  (bus.coef_last)
  );

  assign bus.tok_ready = tok_rdy;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_jpeg_rle_decoder.sv
// Directed bench for jpeg_rle_decoder: token streams with hand-derived coefficient sequences.
module tb_jpeg_rle_decoder;

  localparam int DW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  jpeg_rle_decoder_if #(.DW(DW)) bus ();

  jpeg_rle_decoder #(.DW(DW), .BLK(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  bit rand_rdy = 1'b0;
  int got_c[$], got_i[$], got_l[$];
  int exp_c[$], exp_i[$], exp_l[$];

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic monitor();
    bit stall;
    int hc, hi, hl;
    stall = 1'b0;
    hc = 0; hi = 0; hl = 0;
    forever begin
      @(negedge clk);
      if (rst && stall) begin
        chk("hold_valid", int'(bus.coef_valid), 1);
        chk("hold_coef", int'(bus.coef), hc);
        chk("hold_idx", int'(bus.coef_idx), hi);
        chk("hold_last", int'(bus.coef_last), hl);
      end
      if (rst && bus.coef_valid && bus.coef_ready) begin
        got_c.push_back(int'(bus.coef));
        got_i.push_back(int'(bus.coef_idx));
        got_l.push_back(int'(bus.coef_last));
        $display("coef idx=%0d value=%0d last=%0d", bus.coef_idx, bus.coef, bus.coef_last);
      end
      if (bus.err === 1'b1) err_cnt++;
      stall = rst && bus.coef_valid && !bus.coef_ready;
      hc = int'(bus.coef);
      hi = int'(bus.coef_idx);
      hl = int'(bus.coef_last);
    end
  endtask

  task automatic ready_driver();
    bus.coef_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.coef_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic clear_q();
    got_c.delete(); got_i.delete(); got_l.delete();
    exp_c.delete(); exp_i.delete(); exp_l.delete();
  endtask

  task automatic push_exp(input int c, input int i);
    exp_c.push_back(c);
    exp_i.push_back(i);
    exp_l.push_back((i == 63) ? 1 : 0);
  endtask

  task automatic push_zeros(input int from, input int to);
    for (int i = from; i <= to; i++) push_exp(0, i);
  endtask

  // Entered and left at posedge+1.
  task automatic send_tok(input bit dc, input int r, input int s, input int a);
    int n;
    n = 0;
    bus.tok_valid = 1'b1;
    bus.dcterm    = dc;
    bus.rlen      = 4'(r);
    bus.size      = 4'(s);
    bus.amp       = 12'(a);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tok_ready && n < 3000);
    chk("tok_accept", int'(bus.tok_ready), 1);
    $display("token dc=%0d rlen=%0d size=%0d amp=%0d", dc, r, s, a);
    @(posedge clk);
    #1;
    bus.tok_valid = 1'b0;
  endtask

  task automatic wait_count(input int n);
    int t;
    t = 0;
    while (got_c.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic compare_stream(input string tag);
    chk({tag, ".count"}, got_c.size(), exp_c.size());
    for (int k = 0; k < exp_c.size() && k < got_c.size(); k++) begin
      chk($sformatf("%s[%0d].coef", tag, k), got_c[k], exp_c[k]);
      chk($sformatf("%s[%0d].idx", tag, k), got_i[k], exp_i[k]);
      chk($sformatf("%s[%0d].last", tag, k), got_l[k], exp_l[k]);
    end
  endtask

  initial begin
    int e0;
    int t;
    bus.tok_valid = 1'b0;
    bus.dcterm    = 1'b0;
    bus.rlen      = 4'd0;
    bus.size      = 4'd0;
    bus.amp       = '0;
    fork
      monitor();
      ready_driver();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.tok_ready", int'(bus.tok_ready), 0);
    chk("rst.coef_valid", int'(bus.coef_valid), 0);
    chk("rst.coef", int'(bus.coef), 0);
    chk("rst.coef_idx", int'(bus.coef_idx), 0);
    chk("rst.coef_last", int'(bus.coef_last), 0);
    chk("rst.err", int'(bus.err), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst.ready_release_cycle", int'(bus.tok_ready), 0);
    @(negedge clk);
    chk("rst.ready_next_cycle", int'(bus.tok_ready), 1);
    @(posedge clk);
    #1;

    // AC token while waiting for DC: dropped with err
    clear_q();
    send_tok(1'b0, 0, 1, 3);
    @(negedge clk);
    chk("s0.err_pulse", int'(bus.err), 1);
    repeat (3) @(negedge clk);
    chk("s0.no_coef", got_c.size(), 0);
    @(posedge clk);
    #1;

    // Scenario 1: basic block
    clear_q();
    e0 = err_cnt;
    send_tok(1'b1, 0, 6, -37);
    send_tok(1'b0, 0, 3, 5);
    send_tok(1'b0, 2, 1, -1);
    send_tok(1'b0, 0, 0, 0);
    wait_count(64);
    push_exp(-37, 0); push_exp(5, 1); push_zeros(2, 3); push_exp(-1, 4); push_zeros(5, 63);
    compare_stream("s1");
    chk("s1.err", err_cnt - e0, 0);

    // Scenario 2: ZRL chain ending exactly at 63, then invalid size=0 token as EOB
    clear_q();
    e0 = err_cnt;
    send_tok(1'b1, 0, 4, 10);
    @(negedge clk);
    chk("s2.lat_valid", int'(bus.coef_valid), 1);
    chk("s2.lat_coef", int'(bus.coef), 10);
    chk("s2.lat_idx", int'(bus.coef_idx), 0);
    @(posedge clk);
    #1;
    send_tok(1'b0, 15, 0, 0);
    send_tok(1'b0, 15, 0, 0);
    send_tok(1'b0, 15, 0, 0);
    send_tok(1'b0, 14, 3, 7);
    wait_count(64);
    chk("s2.err_block1", err_cnt - e0, 0);
    send_tok(1'b1, 0, 1, -1);
    send_tok(1'b0, 5, 0, 0);
    @(negedge clk);
    chk("s2.badsize_err", int'(bus.err), 1);
    @(posedge clk);
    #1;
    wait_count(128);
    push_exp(10, 0); push_zeros(1, 62); push_exp(7, 63);
    push_exp(-1, 0); push_zeros(1, 63);
    compare_stream("s2");
    chk("s2.err_total", err_cnt - e0, 1);

    // Scenario 3: scenario 1 under random backpressure
    clear_q();
    e0 = err_cnt;
    rand_rdy = 1'b1;
    send_tok(1'b1, 0, 6, -37);
    send_tok(1'b0, 0, 3, 5);
    send_tok(1'b0, 2, 1, -1);
    send_tok(1'b0, 0, 0, 0);
    wait_count(64);
    rand_rdy = 1'b0;
    push_exp(-37, 0); push_exp(5, 1); push_zeros(2, 3); push_exp(-1, 4); push_zeros(5, 63);
    compare_stream("s3");
    chk("s3.err", err_cnt - e0, 0);
    @(posedge clk);
    #1;

    // Scenario 4: run past index 63 is truncated
    clear_q();
    e0 = err_cnt;
    send_tok(1'b1, 0, 3, 4);
    send_tok(1'b0, 15, 0, 0);
    send_tok(1'b0, 15, 0, 0);
    send_tok(1'b0, 15, 0, 0);
    send_tok(1'b0, 1, 2, 3);
    send_tok(1'b0, 15, 3, 2);
    @(negedge clk);
    chk("s4.ovf_err_pulse", int'(bus.err), 1);
    @(posedge clk);
    #1;
    send_tok(1'b1, 0, 4, 8);
    send_tok(1'b0, 0, 0, 0);
    wait_count(128);
    push_exp(4, 0); push_zeros(1, 49); push_exp(3, 50); push_zeros(51, 63);
    push_exp(8, 0); push_zeros(1, 63);
    compare_stream("s4");
    chk("s4.err_total", err_cnt - e0, 1);

    // Scenario 5: DC token mid-block at index 20 restarts the block
    clear_q();
    e0 = err_cnt;
    send_tok(1'b1, 0, 1, 1);
    send_tok(1'b0, 14, 2, 2);
    send_tok(1'b0, 3, 1, -1);
    send_tok(1'b1, 0, 4, 9);
    @(negedge clk);
    chk("s5.abort_err_pulse", int'(bus.err), 1);
    @(posedge clk);
    #1;
    send_tok(1'b0, 0, 0, 0);
    wait_count(84);
    push_exp(1, 0); push_zeros(1, 14); push_exp(2, 15); push_zeros(16, 18); push_exp(-1, 19);
    push_exp(9, 0); push_zeros(1, 63);
    compare_stream("s5");
    chk("s5.err_total", err_cnt - e0, 1);

    // Scenario 6: reset pulse during fill at index 30
    clear_q();
    send_tok(1'b1, 0, 3, 5);
    send_tok(1'b0, 0, 0, 0);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(bus.coef_valid && bus.coef_idx == 6'd30) && t < 500);
    chk("s6.reach_idx30", int'(bus.coef_idx), 30);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("s6.rst_coef_valid", int'(bus.coef_valid), 0);
    chk("s6.rst_coef_idx", int'(bus.coef_idx), 0);
    chk("s6.rst_coef_last", int'(bus.coef_last), 0);
    @(posedge clk);
    #1;
    push_exp(5, 0); push_zeros(1, 30);
    compare_stream("s6a");
    clear_q();
    send_tok(1'b1, 0, 2, -2);
    send_tok(1'b0, 0, 1, 1);
    send_tok(1'b0, 0, 0, 0);
    wait_count(64);
    push_exp(-2, 0); push_exp(1, 1); push_zeros(2, 63);
    compare_stream("s6b");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
